led_sum_display: RTL and testbench

//  Downstream display stage for the 4-bit adder result (sum[3:0] + carry = 5 bits).
//  - Accepts one result per valid/ready handshake and latches it.
//  - Drives LED0..LED4 for a fixed hold window, then blanks them.
//  - Blinks LED4 (the carry LED) while the window is open; LED0..LED3 are steady.
//  - Sits between the adder and the board LED pins.

---
 rtl/led_sum_display.sv | 129 ++++++++++++
 tb/tb_led_sum_display.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led_sum_display.sv
// Display stage for the 5-bit adder result: latches {carry, sum} per handshake and shows it
// for a fixed window with a blinking carry LED. Optional PWM dimming via `LED_PWM_EN.
module led_sum_display #(
  parameter int HOLD_CYCLES = 10,
  parameter int BLINK_DIV   = 2,
  parameter int PWM_BITS    = 3,
  parameter int PWM_DUTY    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_i,
  input  logic       sum_valid,
  output logic       sum_ready,
  output logic       LED0,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [4:0]      latch, latch_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [BW-1:0]   blink_cnt, blink_nxt;
  logic            blink_ph, ph_nxt;
  logic            xfer;
  logic            gate;
  logic [4:0]      led_nxt;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_nxt;

  assign pwm_nxt = pwm_cnt + PWM_BITS'(1);
  // Gate on the counter value the LEDs will coexist with after this edge.
  assign gate = ({1'b0, pwm_nxt} < (PWM_BITS + 1)'(PWM_DUTY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= {PWM_BITS{1'b0}};
    else     pwm_cnt <= pwm_nxt;
  end
`else
  assign gate = 1'b1;
`endif

  always_comb begin
    xfer      = sum_valid & sum_ready;
    state_nxt = state;
    latch_nxt = latch;
    hold_nxt  = hold_cnt;
    blink_nxt = blink_cnt;
    ph_nxt    = blink_ph;
    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt = SHOW;
          latch_nxt = sum_i;
          hold_nxt  = HOLD_LOAD;
          blink_nxt = {BW{1'b0}};
          ph_nxt    = 1'b1;
        end else begin
          latch_nxt = 5'b0;
        end
      end
      SHOW: begin
        // A new result always wins over expiry of the current window.
        if (xfer) begin
          latch_nxt = sum_i;
          hold_nxt  = HOLD_LOAD;
          blink_nxt = {BW{1'b0}};
          ph_nxt    = 1'b1;
        end else if (hold_cnt == {HW{1'b0}}) begin
          state_nxt = IDLE;
          latch_nxt = 5'b0;
          blink_nxt = {BW{1'b0}};
          ph_nxt    = 1'b1;
        end else begin
          hold_nxt = hold_cnt - HW'(1);
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = {BW{1'b0}};
            ph_nxt    = ~blink_ph;
          end else begin
            blink_nxt = blink_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        latch_nxt = 5'b0;
        hold_nxt  = {HW{1'b0}};
        blink_nxt = {BW{1'b0}};
        ph_nxt    = 1'b1;
      end
    endcase
    if (state_nxt == SHOW && gate) led_nxt = {latch_nxt[4] & ph_nxt, latch_nxt[3:0]};
    else                           led_nxt = 5'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      latch     <= 5'b0;
      hold_cnt  <= {HW{1'b0}};
      blink_cnt <= {BW{1'b0}};
      blink_ph  <= 1'b1;
      sum_ready <= 1'b0;
      busy      <= 1'b0;
      {LED4, LED3, LED2, LED1, LED0} <= 5'b0;
    end else begin
      state     <= state_nxt;
      latch     <= latch_nxt;
      hold_cnt  <= hold_nxt;
      blink_cnt <= blink_nxt;
      blink_ph  <= ph_nxt;
      sum_ready <= 1'b1;
      busy      <= (state_nxt == SHOW);
      {LED4, LED3, LED2, LED1, LED0} <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_sum_display.sv
// Self-checking bench for led_sum_display: a window/age model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_led_sum_display;

  localparam int HOLD = 10;
  localparam int BDIV = 2;
  localparam int PBITS = 3;
  localparam int PDUTY = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sum_i;
  logic       sum_valid;
  logic       sum_ready;
  logic       LED0, LED1, LED2, LED3, LED4;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  led_sum_display #(
    .HOLD_CYCLES(HOLD), .BLINK_DIV(BDIV), .PWM_BITS(PBITS), .PWM_DUTY(PDUTY)
  ) dut (
    .clk(clk), .rst(rst), .sum_i(sum_i), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] leds();
    return {LED4, LED3, LED2, LED1, LED0};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: value, remaining visible cycles, cycles since the latest transfer.
  logic [4:0] m_val;
  int         m_rem, m_age, m_pwm;
  bit         m_rdy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val <= 5'b0; m_rem <= 0; m_age <= 0; m_rdy <= 1'b0; m_pwm <= 0;
    end else begin
      m_rdy <= 1'b1;
      m_pwm <= m_pwm + 1;
      if (sum_valid && m_rdy) begin
        m_val <= sum_i; m_rem <= HOLD; m_age <= 0;
      end else if (m_rem > 0) begin
        m_rem <= m_rem - 1; m_age <= m_age + 1;
      end
    end
  end

  function automatic logic [4:0] model_leds();
    logic gate;
    logic blink_on;
`ifdef LED_PWM_EN
    gate = ((m_pwm % (1 << PBITS)) < PDUTY);
`else
    gate = 1'b1;
`endif
    blink_on = (((m_age / BDIV) % 2) == 0);
    if (m_rem > 0 && gate) return {m_val[4] & blink_on, m_val[3:0]};
    return 5'b0;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_leds", leds(), model_leds());
      chk("model_busy", {4'b0, busy}, {4'b0, (m_rem > 0)});
      chk("model_ready", {4'b0, sum_ready}, {4'b0, m_rdy});
    end
  end

  // Present a value for exactly one accepted cycle; returns at the first visible cycle.
  task automatic send(input logic [4:0] v);
    @(negedge clk);
    sum_i = v; sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0; sum_i = 5'($urandom_range(0, 31));
  endtask

  logic [9:0] blink_exp;
  int on_cnt;

  initial begin
    rst = 1'b1; sum_valid = 1'b0; sum_i = 5'b0;
    @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    chk("reset_leds", leds(), 5'b0);
    chk("reset_ready", {4'b0, sum_ready}, 5'b0);
    chk("reset_busy", {4'b0, busy}, 5'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {4'b0, sum_ready}, 5'b00001);
    chk("idle_leds", leds(), 5'b0);
    sum_i = 5'b11111;
    repeat (2) @(negedge clk);
    chk("idle_no_valid", leds(), 5'b0);

`ifndef LED_PWM_EN
    send(5'b00110);
    for (int i = 0; i < HOLD; i++) begin
      chk("hold_00110", leds(), 5'b00110);
      chk("hold_busy", {4'b0, busy}, 5'b00001);
      @(negedge clk);
    end
    chk("expire_leds", leds(), 5'b0);
    chk("expire_busy", {4'b0, busy}, 5'b0);

    blink_exp = 10'b1100110011;
    send(5'b10001);
    for (int i = 0; i < HOLD; i++) begin
      chk("blink_led4", {3'b0, LED4, LED0}, {3'b0, blink_exp[9 - i], 1'b1});
      @(negedge clk);
    end
    chk("blink_end", leds(), 5'b0);

    send(5'b00011);
    repeat (HOLD - 2) @(negedge clk);
    chk("last_cycle_old", leds(), 5'b00011);
    send(5'b01100);
    for (int i = 0; i < HOLD; i++) begin
      chk("reload_01100", leds(), 5'b01100);
      chk("reload_busy", {4'b0, busy}, 5'b00001);
      @(negedge clk);
    end
    chk("reload_end", leds(), 5'b0);
`endif

    send(5'b11111);
    repeat (2) @(negedge clk);
    chk("pre_reset_show", {1'b0, leds()} > 6'd0 ? 5'b00001 : 5'b0, 5'b00001);
    #3 rst = 1'b1;
    #1;
    chk("async_reset_leds", leds(), 5'b0);
    chk("async_reset_busy", {4'b0, busy}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", leds(), 5'b0);
    chk("after_reset_busy", {4'b0, busy}, 5'b0);
    repeat (HOLD) @(negedge clk);
    chk("no_redisplay", leds(), 5'b0);

`ifdef LED_PWM_EN
    send(5'b01111);
    on_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (LED0) on_cnt++;
      @(negedge clk);
    end
    chk("pwm_on_cycles", 5'(on_cnt), 5'd4);
    repeat (HOLD) @(negedge clk);
`endif

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
